fp_addsub_seq: RTL

//  Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with add/sub select.

---
 rtl/fp_addsub_seq_pkg.sv | 15 +
 rtl/fp_addsub_seq_if.sv | 13 +
 rtl/fp_addsub_seq_lzc.sv | 11 +
 rtl/fp_addsub_seq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fp_addsub_seq_pkg.sv
// fp_addsub_seq_pkg: shared FSM states, default-format constants and operand classifiers
package fp_addsub_seq_pkg;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK} state_t;
  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;
  localparam int BIAS = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << DEF_EXP_W) - 1;
  localparam logic [DEF_EXP_W+DEF_MAN_W:0] QNAN = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};
  function automatic logic fp_is_nan(input logic exp_ones, input logic frac_nz);
    return exp_ones & frac_nz;
  endfunction
  function automatic logic fp_is_inf(input logic exp_ones, input logic frac_nz);
    return exp_ones & ~frac_nz;
  endfunction
endpackage

// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: start/done request bus between a host and the FP add/sub coprocessor
interface fp_addsub_seq_if #(parameter int EXP_W = 5, parameter int MAN_W = 10);
  logic start;
  logic op_sub;
  logic [EXP_W+MAN_W:0] a;
  logic [EXP_W+MAN_W:0] b;
  logic busy;
  logic done;
  logic [EXP_W+MAN_W:0] result;
  logic [3:0] flags;
  modport master(output start, op_sub, a, b, input busy, done, result, flags);
  modport slave(input start, op_sub, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp_addsub_seq_lzc.sv
// fp_lzc: combinational leading-zero counter; all-zero input reports W
module fp_lzc #(parameter int W = 14) (
  input  logic [W-1:0]             x,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int CW = $clog2(W + 1);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (x[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle FP adder/subtractor with flags.
// Define FPADD_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate.
module fp_addsub_seq
  import fp_addsub_seq_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic clk,
  input logic rst_n,
  fp_addsub_seq_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;
  localparam int S = MAN_W + 5;
  localparam int E = EXP_W + 2;
  localparam int LW = $clog2(M + 1);
  localparam logic signed [E-1:0] EMAX = E'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] ONES = '1;
  localparam logic [W-1:0] QNAN_P = {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}};
  state_t state;
  logic [W-1:0] a_q, b_q;
  logic op_q, sign_q, eff_sub_q, nan_q, inval_q, inf_q, inf_sign_q, zero_q;
  logic signed [E-1:0] exp_q;
  logic [EXP_W-1:0] diff_q;
  logic [M-1:0] big_q, small_q, norm_q;
  logic [S-1:0] sum_q;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic sa, sb, a_big, inf_a, inf_b, inc;
  logic [M-1:0] ma, mb, lost, aligned, norm;
  logic [LW-1:0] sh, lz;
  logic [S-1:0] sum;
  logic signed [E-1:0] nexp, rexp;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] res;
  logic [3:0] flg;
  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  assign sa = a_q[W-1];
  assign sb = b_q[W-1] ^ op_q;
  // exp==0 flushes the fraction, so subnormals behave as zero everywhere below
  assign ma = {|ea, fa & {MAN_W{|ea}}, 3'b000};
  assign mb = {|eb, fb & {MAN_W{|eb}}, 3'b000};
  assign a_big = {ea, fa & {MAN_W{|ea}}} >= {eb, fb & {MAN_W{|eb}}};
  assign inf_a = fp_is_inf(&ea, |fa);
  assign inf_b = fp_is_inf(&eb, |fb);
  assign sh = (32'(diff_q) > M) ? LW'(M) : LW'(diff_q);
  assign lost = small_q << (LW'(M) - sh);
  assign aligned = (small_q >> sh) | {{(M-1){1'b0}}, |lost};
  assign sum = eff_sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};
  fp_lzc #(.W(M)) u_lzc (.x(sum_q[M-1:0]), .cnt(lz));
  assign norm = sum_q[S-1] ? {sum_q[S-1:2], |sum_q[1:0]} : sum_q[M-1:0] << lz;
  assign nexp = sum_q[S-1] ? exp_q + E'(1) : exp_q - E'(lz);
`ifdef FPADD_ROUND_NEAREST_EN
  assign inc = norm_q[2] & (|norm_q[1:0] | norm_q[3]);
`else
  assign inc = 1'b0;
`endif
  assign rnd = {1'b0, norm_q[M-1:3]} + (MAN_W+2)'(inc);
  assign rexp = rnd[MAN_W+1] ? exp_q + E'(1) : exp_q;
  assign frac = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
  assign res = nan_q | inval_q ? QNAN_P
             : inf_q ? {inf_sign_q, ONES, {MAN_W{1'b0}}}
             : zero_q ? '0
             : rexp >= EMAX ? {sign_q, ONES, {MAN_W{1'b0}}}
             : rexp <= E'(0) ? {sign_q, {(EXP_W+MAN_W){1'b0}}}
             : {sign_q, rexp[EXP_W-1:0], frac};
  assign flg = nan_q | inval_q ? {inval_q & ~nan_q, 3'b000}
             : inf_q | zero_q ? 4'b0000
             : rexp >= EMAX ? 4'b0110
             : rexp <= E'(0) ? 4'b0011
             : {3'b000, |norm_q[2:0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.flags <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.b;
          op_q <= bus.op_sub;
          bus.busy <= 1'b1;
          state <= UNPACK;
        end
        UNPACK: begin
          sign_q <= a_big ? sa : sb;
          exp_q <= {2'b00, a_big ? ea : eb};
          big_q <= a_big ? ma : mb;
          small_q <= a_big ? mb : ma;
          diff_q <= a_big ? ea - eb : eb - ea;
          eff_sub_q <= sa ^ sb;
          nan_q <= fp_is_nan(&ea, |fa) | fp_is_nan(&eb, |fb);
          inval_q <= inf_a & inf_b & (sa ^ sb);
          inf_q <= inf_a | inf_b;
          inf_sign_q <= inf_a ? sa : sb;
          state <= ALIGN;
        end
        ALIGN: begin
          small_q <= aligned;
          state <= ADD;
        end
        ADD: begin
          sum_q <= sum;
          state <= NORM;
        end
        NORM: begin
          norm_q <= norm;
          exp_q <= nexp;
          zero_q <= ~|sum_q;
          state <= ROUND;
        end
        ROUND: begin
          bus.result <= res;
          bus.flags <= flg;
          bus.done <= 1'b1;
          state <= PACK;
        end
        PACK: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
